// File: rtl/io_in_cond_pkg.sv
// Shared defaults and helpers for the input-conditioning stage.
package io_in_pkg;

  // Board defaults: 50000-cycle sample tick, 10 stable ticks to accept a level
  localparam int unsigned TICK_DIV_DEF     = 50000;
  localparam int unsigned STABLE_TICKS_DEF = 10;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_in_cond_deb_bit.sv
// One-bit two-flop synchroniser followed by a tick-sampled debouncer.
// A new level is accepted only after it has differed from the current
// debounced level on STABLE_TICKS consecutive sample ticks.
module deb_bit
  import io_in_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_deb
);

  localparam int unsigned   CW      = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive mismatching ticks; any return to the held level restarts
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (i_tick) begin
      if (cnt == CNT_MAX) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_deb = deb;

endmodule

// File: rtl/io_in_cond.sv
// Input conditioning for board switches and buttons: synchronise, debounce,
// and derive button rise pulses, sticky press flags and a switch-change pulse.
module io_in_cond
  import io_in_pkg::*;
#(
  parameter int unsigned SW_W         = 32,
  parameter int unsigned BTN_W        = 4,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_sw_raw,
  input  logic [BTN_W-1:0] i_btn_raw,
  input  logic [BTN_W-1:0] i_evt_clr,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_io_btn,
  output logic [BTN_W-1:0] o_btn_rise,
  output logic [BTN_W-1:0] o_btn_evt,
  output logic             o_sw_chg
);

  localparam int unsigned   PW      = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre;
  logic             tick;
  logic [SW_W-1:0]  deb_sw;
  logic [SW_W-1:0]  sw_q;
  logic [BTN_W-1:0] deb_btn;
  logic [BTN_W-1:0] btn_q;
  logic [BTN_W-1:0] rise;
  logic [BTN_W-1:0] evt;
  logic             chg;

  assign tick = (pre == PRE_MAX);

  // Free-running sample-tick prescaler shared by every debouncer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar g = 0; g < SW_W; g++) begin : g_sw
    deb_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_deb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_raw (i_sw_raw[g]),
      .i_tick(tick),
      .o_deb (deb_sw[g])
    );
  end

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    deb_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_deb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_raw (i_btn_raw[g]),
      .i_tick(tick),
      .o_deb (deb_btn[g])
    );
  end

  // Delay debounced levels one cycle and register edge pulses from the difference
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_q  <= '0;
      btn_q <= '0;
      rise  <= '0;
      chg   <= 1'b0;
    end else begin
      sw_q  <= deb_sw;
      btn_q <= deb_btn;
      rise  <= deb_btn & ~btn_q;
      chg   <= |(deb_sw ^ sw_q);
    end
  end

  // Sticky press flags: set while the rise pulse is visible, set beats clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      evt <= '0;
    end else begin
      evt <= (evt & ~i_evt_clr) | rise;
    end
  end

  assign o_io_sw    = deb_sw;
  assign o_io_btn   = deb_btn;
  assign o_btn_rise = rise;
  assign o_btn_evt  = evt;
  assign o_sw_chg   = chg;

endmodule

// File: tb/tb_io_in_cond.sv
// Directed bench for io_in_cond with a short tick (TICK_DIV=4, STABLE_TICKS=3).
module tb_io_in_cond;

  logic        clk;
  logic        rst;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [3:0]  evt_clr;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_rise;
  logic [3:0]  btn_evt;
  logic        sw_chg;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt [4];
  int chg_cnt  = 0;
  int lat;

  io_in_cond #(
    .SW_W        (32),
    .BTN_W       (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sw_raw  (sw_raw),
    .i_btn_raw (btn_raw),
    .i_evt_clr (evt_clr),
    .o_io_sw   (io_sw),
    .o_io_btn  (io_btn),
    .o_btn_rise(btn_rise),
    .o_btn_evt (btn_evt),
    .o_sw_chg  (sw_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge, tallying pulses
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (btn_rise[i] === 1'b1) rise_cnt[i]++;
    if (sw_chg === 1'b1) chg_cnt++;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 4; i++) rise_cnt[i] = 0;
    chg_cnt = 0;
  endtask

  task automatic wait_sw(input logic [31:0] exp, output int n);
    n = 0;
    while (io_sw !== exp && n < 40) begin step(); n++; end
  endtask

  task automatic wait_btn(input logic [3:0] exp, output int n);
    n = 0;
    while (io_btn !== exp && n < 40) begin step(); n++; end
  endtask

  initial begin
    rst = 1'b1; sw_raw = '0; btn_raw = '0; evt_clr = '0;
    clr_counts();
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("reset_sw", io_sw, 32'h0);
    chk("reset_btn", {28'h0, io_btn}, 32'h0);
    chk("reset_evt", {28'h0, btn_evt}, 32'h0);

    // Debounce all switches high, then reset mid-clock: outputs clear at once
    sw_raw = 32'hFFFF_FFFF;
    wait_sw(32'hFFFF_FFFF, lat);
    chk("pre_reset_sw", io_sw, 32'hFFFF_FFFF);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_sw", io_sw, 32'h0);
    chk("async_reset_chg", {31'h0, sw_chg}, 32'h0);
    chk("async_reset_misc", {20'h0, io_btn, btn_rise, btn_evt}, 32'h0);
    step(); step();
    #3 rst = 1'b0;
    clr_counts();
    wait_sw(32'hFFFF_FFFF, lat);
    chk("rerelease_lat_ok", {31'h0, (lat >= 10 && lat <= 15)}, 32'h1);
    step(); step(); step();
    chk("rerelease_sw", io_sw, 32'hFFFF_FFFF);
    chk("rerelease_chg_cnt", chg_cnt, 1);

    // Clean press on button 2
    clr_counts();
    btn_raw = 4'b0100;
    wait_btn(4'b0100, lat);
    chk("press_lat_ok", {31'h0, (lat >= 10 && lat <= 15)}, 32'h1);
    step(); step(); step();
    chk("press_rise_cnt", rise_cnt[2], 1);
    chk("press_rise_now", {28'h0, btn_rise}, 32'h0);
    chk("press_evt", {28'h0, btn_evt}, 32'h4);
    step(); step();
    chk("press_evt_held", {28'h0, btn_evt}, 32'h4);

    // 5-cycle glitch on button 0 is filtered
    clr_counts();
    btn_raw = 4'b0101;
    repeat (5) step();
    btn_raw = 4'b0100;
    repeat (20) step();
    chk("glitch_btn", {28'h0, io_btn}, 32'h4);
    chk("glitch_rise_cnt", rise_cnt[0], 0);
    chk("glitch_evt", {28'h0, btn_evt}, 32'h4);

    // Bounce 1,0,1,0 every 3 cycles, then settle at 1: one rise only
    clr_counts();
    btn_raw = 4'b0101; repeat (3) step();
    btn_raw = 4'b0100; repeat (3) step();
    btn_raw = 4'b0101; repeat (3) step();
    btn_raw = 4'b0100; repeat (3) step();
    chk("bounce_not_yet", {28'h0, io_btn}, 32'h4);
    btn_raw = 4'b0101;
    wait_btn(4'b0101, lat);
    chk("bounce_lat_ok", {31'h0, (lat >= 10 && lat <= 15)}, 32'h1);
    repeat (4) step();
    chk("bounce_rise_cnt", rise_cnt[0], 1);
    chk("bounce_evt", {28'h0, btn_evt}, 32'h5);

    // Release of button 0: level falls, no rise, flag untouched
    clr_counts();
    btn_raw = 4'b0100;
    wait_btn(4'b0100, lat);
    chk("release_lat_ok", {31'h0, (lat >= 10 && lat <= 15)}, 32'h1);
    repeat (4) step();
    chk("release_rise_cnt", rise_cnt[0], 0);
    chk("release_evt", {28'h0, btn_evt}, 32'h5);

    // Plain clear of bit 0, then clearing an already-zero bit
    evt_clr = 4'b0001; step(); evt_clr = 4'b0000;
    chk("clear_evt", {28'h0, btn_evt}, 32'h4);
    evt_clr = 4'b0010; step(); evt_clr = 4'b0000;
    chk("clear_zero_evt", {28'h0, btn_evt}, 32'h4);

    // Clear in the same cycle as the rise pulse: set wins, next clear works
    btn_raw = 4'b0101;
    lat = 0;
    while (btn_rise[0] !== 1'b1 && lat < 40) begin step(); lat++; end
    chk("race_rise_seen", {31'h0, btn_rise[0]}, 32'h1);
    evt_clr = 4'b0001;
    step();
    chk("race_set_wins", {28'h0, btn_evt}, 32'h5);
    chk("race_rise_gone", {28'h0, btn_rise}, 32'h0);
    step();
    evt_clr = 4'b0000;
    chk("race_then_clear", {28'h0, btn_evt}, 32'h4);

    // Multi-bit switch change gives one pulse
    sw_raw = 32'h0;
    wait_sw(32'h0, lat);
    repeat (3) step();
    chk("sw_zero", io_sw, 32'h0);
    clr_counts();
    sw_raw = 32'h0000_00A5;
    wait_sw(32'h0000_00A5, lat);
    chk("multi_lat_ok", {31'h0, (lat >= 10 && lat <= 15)}, 32'h1);
    repeat (4) step();
    chk("multi_sw", io_sw, 32'h0000_00A5);
    chk("multi_chg_cnt", chg_cnt, 1);
    chk("multi_chg_now", {31'h0, sw_chg}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
